// File: rtl/nitc_risc24_pkg.sv
// Shared definitions for the NITC-RISC24 control path: opcodes, FSM states
// and the datapath mux / ALU encodings driven by the control unit.
package nitc_risc24_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_ADI  = 4'h3;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_JAL  = 4'h7;
  localparam logic [3:0] OP_JLR  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_NAND = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_REGA   = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/nitc_risc24_control_unit.sv
// Multicycle control FSM for NITC-RISC24: one state register plus a purely
// combinational decoder for every datapath enable, strobe and mux select.
module nitc_risc24_control_unit
  import nitc_risc24_pkg::*;
#(
  parameter bit ILLEGAL_HALTS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       flag_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic [1:0] wb_src,
  output logic       instr_done,
  output logic       illegal,
  output logic       halted
);

  state_t r_state;
  state_t w_state_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    flag_write   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    pc_src       = PC_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REGB;
    alu_op       = ALU_ADD;
    reg_dst      = 1'b0;
    wb_src       = WB_ALUOUT;
    instr_done   = 1'b0;
    illegal      = 1'b0;
    halted       = 1'b0;

    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_state_next = S_DECODE;
      end
      // Branch target PC+imm is precomputed here into ALUOut.
      S_DECODE: begin
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_ADD, OP_SUB, OP_NAND: w_state_next = S_EXEC_R;
          OP_ADI:                  w_state_next = S_EXEC_I;
          OP_LW, OP_SW:            w_state_next = S_MEM_ADDR;
          OP_BEQ:                  w_state_next = S_BRANCH;
          OP_JAL, OP_JLR:          w_state_next = S_JUMP;
          OP_HLT:                  w_state_next = S_HALT;
          default: begin
            illegal      = 1'b1;
            instr_done   = 1'b1;
            w_state_next = ILLEGAL_HALTS ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        case (opcode)
          OP_SUB:  alu_op = ALU_SUB;
          OP_NAND: alu_op = ALU_NAND;
          default: alu_op = ALU_ADD;
        endcase
        w_state_next = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        w_state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write    = 1'b1;
        flag_write   = 1'b1;
        reg_dst      = (opcode != OP_ADI);
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        w_state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) w_state_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) w_state_next = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write    = 1'b1;
        wb_src       = WB_MDR;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_REGB;
        alu_op       = ALU_SUB;
        pc_write     = alu_zero;
        pc_src       = PC_ALUOUT;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end
      // Link register receives the already-incremented PC.
      S_JUMP: begin
        reg_write    = 1'b1;
        wb_src       = WB_PC;
        pc_write     = 1'b1;
        pc_src       = (opcode == OP_JLR) ? PC_REGA : PC_ALUOUT;
        instr_done   = 1'b1;
        w_state_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_nitc_risc24_control_unit.sv
// Bench for nitc_risc24_control_unit: two instances (illegal-as-NOP and
// illegal-halts) compared every cycle against an instruction-step model.
module tb_nitc_risc24_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       flag_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic [1:0] wb_src;
    logic       instr_done;
    logic       illegal;
    logic       halted;
  } ctl_t;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       alu_zero;
  logic       mem_ready;

  logic [1:0] pc_write_w, ir_write_w, reg_write_w, flag_write_w;
  logic [1:0] mem_read_w, mem_write_w, iord_w, alu_src_a_w, reg_dst_w;
  logic [1:0] instr_done_w, illegal_w, halted_w;
  logic [1:0] pc_src_w [2];
  logic [1:0] alu_src_b_w [2];
  logic [1:0] alu_op_w [2];
  logic [1:0] wb_src_w [2];
  ctl_t       act [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    nitc_risc24_control_unit #(.ILLEGAL_HALTS(gi == 1)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .alu_zero   (alu_zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write_w[gi]),
      .ir_write   (ir_write_w[gi]),
      .reg_write  (reg_write_w[gi]),
      .flag_write (flag_write_w[gi]),
      .mem_read   (mem_read_w[gi]),
      .mem_write  (mem_write_w[gi]),
      .iord       (iord_w[gi]),
      .pc_src     (pc_src_w[gi]),
      .alu_src_a  (alu_src_a_w[gi]),
      .alu_src_b  (alu_src_b_w[gi]),
      .alu_op     (alu_op_w[gi]),
      .reg_dst    (reg_dst_w[gi]),
      .wb_src     (wb_src_w[gi]),
      .instr_done (instr_done_w[gi]),
      .illegal    (illegal_w[gi]),
      .halted     (halted_w[gi])
    );
    assign act[gi] = {pc_write_w[gi], ir_write_w[gi], reg_write_w[gi], flag_write_w[gi],
                      mem_read_w[gi], mem_write_w[gi], iord_w[gi], pc_src_w[gi],
                      alu_src_a_w[gi], alu_src_b_w[gi], alu_op_w[gi], reg_dst_w[gi],
                      wb_src_w[gi], instr_done_w[gi], illegal_w[gi], halted_w[gi]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: step 0 = fetch, 1 = decode, 2.. = per-instruction steps.
  int         m_step [2];
  bit         m_halt [2];
  logic [3:0] m_op   [2];
  ctl_t       s0, s1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic bit is_illegal(input logic [3:0] op);
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

  function automatic int instr_len(input logic [3:0] op);
    if (op <= 4'h3) return 4;
    if (op == 4'h4) return 5;
    if (op == 4'h5) return 4;
    return 3;
  endfunction

  function automatic ctl_t exp_ctl(input bit halt, input int step, input logic [3:0] op,
                                   input bit mr, input bit az);
    ctl_t c;
    c = '0;
    if (halt) begin
      c.halted = 1'b1;
      return c;
    end
    if (step == 0) begin
      c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr;
      return c;
    end
    if (step == 1) begin
      c.alu_src_b = 2'b10;
      if (is_illegal(op)) begin c.illegal = 1'b1; c.instr_done = 1'b1; end
      return c;
    end
    if (op <= 4'h2) begin
      if (step == 2) begin c.alu_src_a = 1'b1; c.alu_op = op[1:0]; end
      else begin c.reg_write = 1'b1; c.flag_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
    end else if (op == 4'h3) begin
      if (step == 2) begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      else begin c.reg_write = 1'b1; c.flag_write = 1'b1; c.instr_done = 1'b1; end
    end else if (op == 4'h4 || op == 4'h5) begin
      if (step == 2) begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      else if (step == 3 && op == 4'h4) begin c.mem_read = 1'b1; c.iord = 1'b1; end
      else if (step == 3) begin c.mem_write = 1'b1; c.iord = 1'b1; c.instr_done = mr; end
      else begin c.reg_write = 1'b1; c.wb_src = 2'b01; c.instr_done = 1'b1; end
    end else if (op == 4'h6) begin
      c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write = az; c.pc_src = 2'b01; c.instr_done = 1'b1;
    end else begin
      c.reg_write = 1'b1; c.wb_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1;
      c.pc_src = (op == 4'h7) ? 2'b01 : 2'b10;
    end
    return c;
  endfunction

  task automatic advance(input int k, input bit ih);
    if (m_halt[k]) return;
    if (m_step[k] == 0) begin
      if (mem_ready) m_step[k] = 1;
    end else if (m_step[k] == 1) begin
      m_op[k] = opcode;
      if (opcode == 4'hF) m_halt[k] = 1'b1;
      else if (is_illegal(opcode)) begin
        if (ih) m_halt[k] = 1'b1;
        else m_step[k] = 0;
      end else m_step[k] = 2;
    end else if (!(m_step[k] == 3 && (m_op[k] == 4'h4 || m_op[k] == 4'h5) && !mem_ready)) begin
      m_step[k] = m_step[k] + 1;
      if (m_step[k] == instr_len(m_op[k])) m_step[k] = 0;
    end
  endtask

  // One clock: drive at posedge+1, compare on negedge, advance the model on posedge.
  task automatic step_cycle(input bit mr, input bit az, input logic [3:0] op, input bit rst);
    mem_ready = mr;
    alu_zero  = az;
    opcode    = op;
    reset     = !rst;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin m_step[k] = 0; m_halt[k] = 1'b0; end
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk($sformatf("ctl%0d step%0d op%0h", k, m_step[k], op), act[k],
          exp_ctl(m_halt[k], m_step[k], (m_step[k] <= 1) ? op : m_op[k], mr, az));
    s0 = act[0];
    s1 = act[1];
    @(posedge clk);
    if (!rst) begin
      advance(0, 1'b0);
      advance(1, 1'b1);
    end
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input bit az, input int nwait, output int cyc);
    int w;
    bit done, mr;
    w = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 30) begin
      mr = 1'b1;
      if (m_step[0] == 3 && w < nwait) begin mr = 1'b0; w++; end
      step_cycle(mr, az, op, 1'b0);
      cyc++;
      done = s0.instr_done;
    end
    chk($sformatf("done_in_bound op%0h", op), {31'd0, done}, 32'd1);
  endtask

  initial begin
    int cyc;
    bit mr, rst;
    logic [3:0] op;
    reset = 1'b0; mem_ready = 1'b0; alu_zero = 1'b0; opcode = 4'h0;
    for (int k = 0; k < 2; k++) begin m_step[k] = 0; m_halt[k] = 1'b0; m_op[k] = 4'h0; end

    step_cycle(1'b1, 1'b0, 4'h0, 1'b1);
    step_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    chk("rst_mem_read", {31'd0, s0.mem_read}, 32'd1);
    chk("rst_halted", {31'd0, s0.halted}, 32'd0);
    chk("rst_done", {31'd0, s0.instr_done}, 32'd0);

    run_instr(4'h0, 1'b0, 0, cyc);
    chk("add_cycles", cyc, 4);
    chk("add_reg_write", {31'd0, s0.reg_write}, 32'd1);
    chk("add_reg_dst", {31'd0, s0.reg_dst}, 32'd1);

    run_instr(4'h4, 1'b0, 2, cyc);
    chk("lw_cycles", cyc, 7);
    chk("lw_wb_src", {30'd0, s0.wb_src}, 32'd1);

    run_instr(4'h6, 1'b1, 0, cyc);
    chk("beq_taken_cycles", cyc, 3);
    chk("beq_taken_pc_write", {31'd0, s0.pc_write}, 32'd1);
    chk("beq_pc_src", {30'd0, s0.pc_src}, 32'd1);
    run_instr(4'h6, 1'b0, 0, cyc);
    chk("beq_nt_cycles", cyc, 3);
    chk("beq_nt_pc_write", {31'd0, s0.pc_write}, 32'd0);

    run_instr(4'h8, 1'b0, 0, cyc);
    chk("jlr_cycles", cyc, 3);
    chk("jlr_pc_src", {30'd0, s0.pc_src}, 32'd2);
    chk("jlr_wb_src", {30'd0, s0.wb_src}, 32'd2);
    chk("jlr_reg_write", {31'd0, s0.reg_write}, 32'd1);

    run_instr(4'h5, 1'b0, 1, cyc);
    chk("sw_wait_cycles", cyc, 5);

    run_instr(4'hB, 1'b0, 0, cyc);
    chk("ill_cycles", cyc, 2);
    chk("ill_pulse0", {31'd0, s0.illegal}, 32'd1);
    chk("ill_pulse1", {31'd0, s1.illegal}, 32'd1);
    step_cycle(1'b0, 1'b0, 4'h0, 1'b0);
    chk("ill_nop_fetch", {31'd0, s0.mem_read}, 32'd1);
    chk("ill_nop_no_pulse", {31'd0, s0.illegal}, 32'd0);
    chk("ill_halts", {31'd0, s1.halted}, 32'd1);
    step_cycle(1'b0, 1'b0, 4'h0, 1'b1);

    step_cycle(1'b1, 1'b0, 4'h0, 1'b0);
    step_cycle(1'b1, 1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'hF, 1'b0);
      chk($sformatf("hlt_halted_%0d", i), {31'd0, s0.halted}, 32'd1);
      chk($sformatf("hlt_enables_%0d", i),
          {26'd0, s0.pc_write, s0.ir_write, s0.reg_write, s0.flag_write, s0.mem_read, s0.mem_write}, 32'd0);
    end
    step_cycle(1'b0, 1'b0, 4'h0, 1'b1);

    step_cycle(1'b1, 1'b0, 4'h4, 1'b0);
    step_cycle(1'b1, 1'b0, 4'h4, 1'b0);
    step_cycle(1'b1, 1'b0, 4'h4, 1'b0);
    step_cycle(1'b0, 1'b0, 4'h4, 1'b0);
    chk("memrd_iord", {31'd0, s0.iord}, 32'd1);
    step_cycle(1'b1, 1'b0, 4'h4, 1'b1);
    chk("abort_mem_read", {31'd0, s0.mem_read}, 32'd1);
    chk("abort_iord", {31'd0, s0.iord}, 32'd0);
    chk("abort_reg_write", {31'd0, s0.reg_write}, 32'd0);
    step_cycle(1'b1, 1'b0, 4'h4, 1'b0);
    chk("release_fetch", {31'd0, s0.mem_read}, 32'd1);
    chk("release_halted", {31'd0, s0.halted}, 32'd0);
    chk("release_reg_write", {31'd0, s0.reg_write}, 32'd0);

    op = 4'h0;
    for (int i = 0; i < 2000; i++) begin
      mr  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 39) == 0) || (m_halt[1] && $urandom_range(0, 3) == 0);
      if (m_step[0] == 0) op = 4'($urandom_range(0, 15));
      step_cycle(mr, 1'($urandom_range(0, 1)), op, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nitc_risc24_control_unit.md
# nitc_risc24_control_unit

Multicycle control FSM for the NITC-RISC24 processor. It sequences the shared datapath (one ALU, one unified memory port, register file, IR, PC) through fetch, decode, execute, memory and write-back steps, and drives every datapath enable and mux select. It sits inside `nitc_risc24_processor` beside the datapath. It accepts a memory handshake so that memories with wait states stall the sequence rather than corrupt it.

## Interface
- `ILLEGAL_HALTS`, default 0: 1 = an undefined opcode enters HALT; 0 = it is retired as a NOP with an `illegal` pulse.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. Low forces FETCH and clears all registered outputs immediately.
- `opcode` input 4: IR[15:12], valid from DECODE onward.
- `alu_zero` input 1: combinational ALU zero flag for the current cycle.
- `mem_ready` input 1: memory completes the current read or write this cycle.
- `pc_write`, `ir_write`, `reg_write`, `flag_write` output 1: write enables.
- `mem_read`, `mem_write` output 1: memory strobes, held until `mem_ready`.
- `iord` output 1: memory address source; 0 = PC, 1 = ALUOut.
- `pc_src` output 2: 00 = ALU result, 01 = ALUOut, 10 = register A.
- `alu_src_a` output 1: 0 = PC, 1 = register A.
- `alu_src_b` output 2: 00 = register B, 01 = constant 1, 10 = sign-extended immediate.
- `alu_op` output 2: 00 = ADD, 01 = SUB, 10 = NAND.
- `reg_dst` output 1: 0 = rt, 1 = rd.
- `wb_src` output 2: 00 = ALUOut, 01 = MDR, 10 = PC.
- `instr_done` output 1: one-cycle pulse on the last cycle of each instruction.
- `illegal`, `halted` output 1: status outputs.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 NAND (R-type); 3 ADI; 4 LW; 5 SW; 6 BEQ; 7 JAL; 8 JLR; F HLT. Opcodes 9–E are illegal.
- States and transitions:
  - FETCH → DECODE.
  - DECODE → EXEC_R (0–2), EXEC_I (3), MEM_ADDR (4, 5), BRANCH (6), JUMP (7, 8), HALT (F).
  - Illegal opcode in DECODE → FETCH, or → HALT when `ILLEGAL_HALTS` = 1.
  - EXEC_R / EXEC_I → WB_ALU.
  - MEM_ADDR → MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD → WB_MEM.
  - WB_ALU, WB_MEM, MEM_WR, BRANCH, JUMP → FETCH.
  - HALT → HALT.
- FETCH:
  - `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=ADD.
  - `ir_write` and `pc_write` equal `mem_ready`, with `pc_src`=00.
  - Stays in FETCH while `mem_ready`=0.
- DECODE: computes PC+imm into ALUOut (`alu_src_a`=0, `alu_src_b`=10, ADD) for the branch target.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=00; `alu_op` from opcode (0→ADD, 1→SUB, 2→NAND).
- EXEC_I: `alu_src_a`=1, `alu_src_b`=10, ADD.
- WB_ALU: `reg_write`=1, `wb_src`=00, `flag_write`=1. `reg_dst`=1 for R-type, 0 for ADI.
- MEM_ADDR: A+imm (`alu_src_a`=1, `alu_src_b`=10, ADD).
- MEM_RD: `mem_read`=1, `iord`=1; waits for `mem_ready`.
- MEM_WR: `mem_write`=1, `iord`=1; waits for `mem_ready`.
- WB_MEM: `reg_write`=1, `wb_src`=01, `reg_dst`=0.
- BRANCH: A−B (`alu_src_a`=1, `alu_src_b`=00, SUB); `pc_write`=`alu_zero`, `pc_src`=01.
- JUMP:
  - `reg_write`=1, `wb_src`=10, `reg_dst`=0 (link register = PC+1).
  - `pc_write`=1.
  - `pc_src`=01 for JAL, 10 for JLR.
- HALT: all enables and strobes 0, `halted`=1. Only `reset` exits.
- Every control not listed for a state is 0.

## Timing
- `reset` low: state = FETCH; `instr_done`=0, `illegal`=0, `halted`=0 asynchronously. All combinational enables then follow FETCH.
- On the first edge after reset release, FETCH is active with `mem_read`=1.
- Outputs are combinational from the state register plus the signals named above (`mem_ready`, `alu_zero`, `opcode`). There are no registered output delays.
- Cycles per instruction with zero-wait memory: R-type/ADI 4, LW 5, SW 4, BEQ 3, JAL/JLR 3. Each memory wait cycle adds 1.
- `instr_done` asserts on:
  - WB_ALU, WB_MEM and BRANCH, JUMP;
  - MEM_WR when `mem_ready`=1;
  - DECODE for an illegal opcode.
- `illegal` is a one-cycle pulse in DECODE.
- `opcode` is sampled only in DECODE and in states that branch on it. `opcode` changes elsewhere are ignored.
- `reset` asserted mid-instruction (including during a memory wait) aborts it. No partial write enable is generated after the reset edge.

## Structure
- Shared package `nitc_risc24_pkg` holds:
  - the opcode localparams;
  - the state enum (4-bit);
  - the `alu_op`, `alu_src_b`, `pc_src` and `wb_src` encodings.
- The block is a single module: one state register plus a combinational output decoder. No sub-module.

## Test plan
- Reset low for 10 ns mid-MEM_RD, then release → FETCH with `mem_read`=1, `halted`=0, no `reg_write` pulse.
- Opcode 0 (ADD), `mem_ready` always 1 → states FETCH, DECODE, EXEC_R, WB_ALU. `reg_write`=1 and `reg_dst`=1 in cycle 4; `instr_done` once.
- Opcode 4 (LW), `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total; `wb_src`=01 on the last cycle.
- Opcode 6 (BEQ): `alu_zero`=1 → `pc_write`=1 with `pc_src`=01 in BRANCH; repeat with `alu_zero`=0 → `pc_write`=0. Both take 3 cycles.
- Opcode 8 (JLR) → `pc_src`=10, `wb_src`=10, `reg_write`=1 in JUMP. Opcode F → `halted`=1 held for 20 cycles with all enables 0.
- Opcode B with `ILLEGAL_HALTS`=0 → `illegal` pulses in DECODE, next state FETCH. With `ILLEGAL_HALTS`=1 → HALT.
